// File: rtl/ext_addrgen_2d.sv
// 2-D external-memory DMA address generator: streams beats between one internal
// memory port and the external databus following start + i*shift + k*incr.
module ext_addrgen_2d #(
  parameter int DATA_W       = 32,
  parameter int IO_ADDR_W    = 32,
  parameter int EXT_ADDR_W   = 10,
  parameter int EXT_PERIOD_W = 10,
  parameter int MEM_ADDR_W   = 10,
  parameter int ADDR_SHIFT   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      abort,
  input  logic                      int_cnt_en,
  output logic                      done,
  output logic [2*EXT_PERIOD_W-1:0] xfer_cnt,
  input  logic [IO_ADDR_W-1:0]      ext_addr,
  input  logic [MEM_ADDR_W-1:0]     int_addr,
  input  logic [MEM_ADDR_W-1:0]     int_incr,
  input  logic [1:0]                direction,
  input  logic [EXT_PERIOD_W-1:0]   iterations,
  input  logic [EXT_PERIOD_W-1:0]   period,
  input  logic [EXT_PERIOD_W-1:0]   duty,
  input  logic [EXT_PERIOD_W-1:0]   delay,
  input  logic [EXT_ADDR_W-1:0]     start,
  input  logic [EXT_ADDR_W-1:0]     shift,
  input  logic [EXT_ADDR_W-1:0]     incr,
  output logic                      databus_valid,
  input  logic                      databus_ready,
  output logic [IO_ADDR_W-1:0]      databus_addr,
  input  logic [DATA_W-1:0]         databus_rdata,
  output logic [DATA_W-1:0]         databus_wdata,
  output logic [DATA_W/8-1:0]       databus_wstrb,
  output logic                      valid,
  output logic                      we,
  output logic [MEM_ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]         data_out,
  input  logic [DATA_W-1:0]         data_in
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 2 * EXT_PERIOD_W;

  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, GAP} state_t;

  state_t                  state_reg, state_next;
  logic                    abort_pend_reg;
  logic [1:0]              dir_reg;
  logic [EXT_PERIOD_W-1:0] iter_reg, period_reg, duty_reg;
  logic [EXT_ADDR_W-1:0]   shift_reg, incr_reg, base_reg, ext_off_reg;
  logic [IO_ADDR_W-1:0]    ext_addr_reg;
  logic [MEM_ADDR_W-1:0]   int_addr_reg, int_incr_reg, int_off_reg;
  logic [EXT_PERIOD_W-1:0] k_reg, i_reg, wait_reg;
  logic [CNT_W-1:0]        xfer_cnt_reg;

  logic start_ok, active, beat, stall, duty_end, last_iter, gap_en, is_e2i, is_i2e;

  assign start_ok  = run && (direction == 2'b01 || direction == 2'b10)
                     && (iterations != '0) && (duty != '0);
  assign active    = (state_reg == ACTIVE);
  assign beat      = active && databus_ready;
  assign stall     = active && !databus_ready;
  assign duty_end  = beat && (k_reg == duty_reg - EXT_PERIOD_W'(1));
  assign last_iter = (i_reg == iter_reg - EXT_PERIOD_W'(1));
  assign gap_en    = (period_reg > duty_reg);
  assign is_e2i    = (dir_reg == 2'b01);
  assign is_i2e    = (dir_reg == 2'b10);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      abort_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      // An abort seen during a stall waits for the handshake before leaving ACTIVE.
      abort_pend_reg <= (state_next != IDLE) && (abort_pend_reg || (abort && stall));
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = (delay != '0) ? DELAY : ACTIVE;
      DELAY:   if (wait_reg == '0) state_next = ACTIVE;
      ACTIVE: begin
        if (duty_end) begin
          if (last_iter)   state_next = IDLE;
          else if (gap_en) state_next = GAP;
        end
      end
      GAP:     if (wait_reg == '0) state_next = ACTIVE;
      default: state_next = IDLE;
    endcase
    if ((state_reg != IDLE) && (abort || abort_pend_reg) && !stall)
      state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_reg      <= '0;
      iter_reg     <= '0;
      period_reg   <= '0;
      duty_reg     <= '0;
      shift_reg    <= '0;
      incr_reg     <= '0;
      base_reg     <= '0;
      ext_off_reg  <= '0;
      ext_addr_reg <= '0;
      int_addr_reg <= '0;
      int_incr_reg <= '0;
      int_off_reg  <= '0;
      k_reg        <= '0;
      i_reg        <= '0;
      wait_reg     <= '0;
      xfer_cnt_reg <= '0;
    end else begin
      if ((state_reg == IDLE) && start_ok) begin
        dir_reg      <= direction;
        iter_reg     <= iterations;
        period_reg   <= period;
        duty_reg     <= duty;
        shift_reg    <= shift;
        incr_reg     <= incr;
        ext_addr_reg <= ext_addr;
        int_addr_reg <= int_addr;
        int_incr_reg <= int_incr;
        base_reg     <= start;
        ext_off_reg  <= start;
        int_off_reg  <= '0;
        k_reg        <= '0;
        i_reg        <= '0;
        xfer_cnt_reg <= '0;
        wait_reg     <= delay - EXT_PERIOD_W'(1);
      end
      if (((state_reg == DELAY) || (state_reg == GAP)) && (wait_reg != '0))
        wait_reg <= wait_reg - EXT_PERIOD_W'(1);
      if (beat) begin
        xfer_cnt_reg <= xfer_cnt_reg + CNT_W'(1);
        if (is_e2i || int_cnt_en)
          int_off_reg <= int_off_reg + int_incr_reg;
        // ext_off tracks base + k*incr incrementally instead of multiplying.
        if (duty_end) begin
          k_reg       <= '0;
          i_reg       <= i_reg + EXT_PERIOD_W'(1);
          base_reg    <= base_reg + shift_reg;
          ext_off_reg <= base_reg + shift_reg;
          wait_reg    <= period_reg - duty_reg - EXT_PERIOD_W'(1);
        end else begin
          k_reg       <= k_reg + EXT_PERIOD_W'(1);
          ext_off_reg <= ext_off_reg + incr_reg;
        end
      end
    end
  end

  assign done          = (state_reg == IDLE);
  assign xfer_cnt      = xfer_cnt_reg;
  assign databus_valid = active;
  assign databus_addr  = ext_addr_reg + (IO_ADDR_W'(ext_off_reg) << ADDR_SHIFT);
  assign databus_wdata = data_in;
  assign databus_wstrb = {STRB_W{active && is_i2e}};
  assign valid         = active && (is_i2e || databus_ready);
  assign we            = active && is_e2i && databus_ready;
  assign addr          = int_addr_reg + int_off_reg;
  assign data_out      = databus_rdata;

endmodule

// File: tb/tb_ext_addrgen_2d.sv
// Scoreboard bench for ext_addrgen_2d: a driver issues transfers and pushes the
// expected beat addresses; a negedge monitor pops and compares on every handshake.
module tb_ext_addrgen_2d;

  localparam int DATA_W = 32, IO_ADDR_W = 32, EXT_ADDR_W = 10;
  localparam int EXT_PERIOD_W = 10, MEM_ADDR_W = 10, ADDR_SHIFT = 1;

  logic clk, rst, run, abort, int_cnt_en, done;
  logic [2*EXT_PERIOD_W-1:0] xfer_cnt;
  logic [IO_ADDR_W-1:0] ext_addr, databus_addr;
  logic [MEM_ADDR_W-1:0] int_addr, int_incr, addr;
  logic [1:0] direction;
  logic [EXT_PERIOD_W-1:0] iterations, period, duty, delay;
  logic [EXT_ADDR_W-1:0] start, shift, incr;
  logic databus_valid, databus_ready, valid, we;
  logic [DATA_W-1:0] databus_rdata, databus_wdata, data_out, data_in;
  logic [DATA_W/8-1:0] databus_wstrb;

  ext_addrgen_2d #(
    .DATA_W(DATA_W), .IO_ADDR_W(IO_ADDR_W), .EXT_ADDR_W(EXT_ADDR_W),
    .EXT_PERIOD_W(EXT_PERIOD_W), .MEM_ADDR_W(MEM_ADDR_W), .ADDR_SHIFT(ADDR_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort), .int_cnt_en(int_cnt_en),
    .done(done), .xfer_cnt(xfer_cnt), .ext_addr(ext_addr), .int_addr(int_addr),
    .int_incr(int_incr), .direction(direction), .iterations(iterations),
    .period(period), .duty(duty), .delay(delay), .start(start), .shift(shift),
    .incr(incr), .databus_valid(databus_valid), .databus_ready(databus_ready),
    .databus_addr(databus_addr), .databus_rdata(databus_rdata),
    .databus_wdata(databus_wdata), .databus_wstrb(databus_wstrb), .valid(valid),
    .we(we), .addr(addr), .data_out(data_out), .data_in(data_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard state shared between driver and monitor
  logic [IO_ADDR_W-1:0] exp_q[$];
  logic [1:0] exp_dir = 2'b01;
  int exp_int_addr = 0, exp_int_incr = 0, en_cnt = 0;
  int first_valid_cyc = -1, valid_cycles = 0, run_cyc = 0;
  bit stall_prev = 0;
  logic [IO_ADDR_W-1:0] held_daddr;
  logic [MEM_ADDR_W-1:0] held_maddr;

  int rdy_mode = 0, en_mode = 0, stall_lo = -1, stall_hi = -1;
  logic [3:0] en_pat = 4'b0;

  // Per-cycle input driver: ready, int_cnt_en and data buses
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       databus_ready = ($urandom_range(0, 3) != 0);
        2:       databus_ready = !((cyc >= stall_lo) && (cyc <= stall_hi));
        default: databus_ready = 1'b1;
      endcase
      if (en_mode == 1) begin
        int idx;
        idx = cyc - run_cyc - 1;
        int_cnt_en = (idx >= 0 && idx < 4) ? en_pat[idx] : 1'b0;
      end else begin
        int_cnt_en = 1'($urandom);
      end
      data_in       = $urandom;
      databus_rdata = $urandom;
    end
  end

  // Monitor: compares every bus cycle against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (databus_valid) begin
        logic [31:0] exp_maddr;
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        chk("valid_expected", 64'(exp_q.size() != 0), 64'd1);
        if (stall_prev) begin
          chk("stall_hold_daddr", databus_addr, held_daddr);
          chk("stall_hold_addr", addr, held_maddr);
        end
        chk("wstrb", databus_wstrb, (exp_dir == 2'b10) ? 64'hF : 64'h0);
        exp_maddr = 32'(exp_int_addr) + 32'(exp_int_incr) * 32'(en_cnt);
        chk("mem_addr", addr, exp_maddr[MEM_ADDR_W-1:0]);
        if (exp_dir == 2'b01) begin
          chk("e2i_we", we, databus_ready);
          chk("e2i_valid", valid, databus_ready);
          chk("e2i_data", data_out, databus_rdata);
        end else begin
          chk("i2e_we", we, 0);
          chk("i2e_valid", valid, 1);
          chk("i2e_wdata", databus_wdata, data_in);
        end
        if (databus_ready) begin
          if (exp_q.size() != 0) chk("beat_addr", databus_addr, exp_q.pop_front());
          if (exp_dir == 2'b01 || int_cnt_en) en_cnt++;
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          held_daddr = databus_addr;
          held_maddr = addr;
        end
      end else begin
        stall_prev = 0;
        chk("quiet", {valid, we, databus_wstrb}, 0);
      end
    end
  end

  // Reference model: flat list of beat addresses from start + i*shift + k*incr
  task automatic push_model(input int it, input int du, input int st, input int sh,
                            input int inc, input logic [IO_ADDR_W-1:0] ea);
    for (int i = 0; i < it; i++) begin
      for (int k = 0; k < du; k++) begin
        int unsigned off;
        off = (st + i * sh + k * inc) % (1 << EXT_ADDR_W);
        exp_q.push_back(ea + (IO_ADDR_W'(off) << ADDR_SHIFT));
      end
    end
  endtask

  task automatic run_xfer(input logic [1:0] dir, input int it, input int du, input int pe,
                          input int de, input int st, input int sh, input int inc,
                          input logic [IO_ADDR_W-1:0] ea, input int ia, input int iinc);
    @(posedge clk);
    #1;
    direction = dir; iterations = 10'(it); duty = 10'(du); period = 10'(pe);
    delay = 10'(de); start = 10'(st); shift = 10'(sh); incr = 10'(inc);
    ext_addr = ea; int_addr = 10'(ia); int_incr = 10'(iinc);
    run = 1'b1;
    run_cyc = cyc;
    first_valid_cyc = -1;
    valid_cycles = 0;
    if ((dir == 2'b01 || dir == 2'b10) && it != 0 && du != 0) begin
      exp_dir = dir;
      exp_int_addr = ia;
      exp_int_incr = iinc;
      en_cnt = 0;
      push_model(it, du, st, sh, inc, ea);
    end
    @(posedge clk);
    #1;
    run = 1'b0;
    // Configuration must already be latched; scramble it to prove that
    direction = 2'($urandom); iterations = 10'($urandom); duty = 10'($urandom);
    period = 10'($urandom); delay = 10'($urandom); start = 10'($urandom);
    shift = 10'($urandom); incr = 10'($urandom); ext_addr = $urandom;
    int_addr = 10'($urandom); int_incr = 10'($urandom);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0, expected done=1 within 3000 cycles");
    end
  endtask

  task automatic noop(input logic [1:0] dir, input int it, input int du);
    logic [2*EXT_PERIOD_W-1:0] prev;
    prev = xfer_cnt;
    run_xfer(dir, it, du, 4, 0, 0, 1, 1, 32'h3000, 0, 1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("noop_done", done, 1);
    end
    chk("noop_xfer_held", xfer_cnt, prev);
    $display("noop run dir=%b iter=%0d duty=%0d stayed idle", dir, it, du);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int dc;

  initial begin
    rst = 1'b1; run = 1'b0; abort = 1'b0; int_cnt_en = 1'b0; databus_ready = 1'b1;
    direction = 2'b00; iterations = '0; period = '0; duty = '0; delay = '0;
    start = '0; shift = '0; incr = '0; ext_addr = '0; int_addr = '0; int_incr = '0;
    databus_rdata = '0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done", done, 1);
    chk("rst_dbvalid", databus_valid, 0);
    chk("rst_wstrb", databus_wstrb, 0);
    chk("rst_valid", valid, 0);
    chk("rst_we", we, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_addr", addr, 0);

    // 8 back-to-back beats, 2 rows of 4
    run_xfer(2'b01, 2, 4, 4, 0, 0, 4, 1, 32'h1000, 0, 1);
    wait_done(dc);
    chk("t1_first_valid", first_valid_cyc, run_cyc + 1);
    chk("t1_done_cyc", dc, run_cyc + 9);
    chk("t1_xfer_cnt", xfer_cnt, 8);
    chk("t1_queue_empty", exp_q.size(), 0);
    $display("xfer e2i 2x4 done at +%0d beats=%0d", dc - run_cyc, xfer_cnt);

    noop(2'b01, 0, 4);
    noop(2'b11, 2, 4);
    noop(2'b01, 2, 0);

    // duty 3 of period 5: two idle gap cycles between rows
    run_xfer(2'b01, 2, 3, 5, 0, 0, 10, 1, 32'h0, 0, 1);
    wait_done(dc);
    chk("t2_done_cyc", dc, run_cyc + 9);
    chk("t2_valid_cycles", valid_cycles, 6);
    $display("xfer gap 2x3/5 done at +%0d", dc - run_cyc);

    // negative increment wraps the 10-bit offset
    run_xfer(2'b01, 1, 3, 3, 0, 0, 0, 1023, 32'h0, 0, 1);
    wait_done(dc);
    chk("neg_done_cyc", dc, run_cyc + 4);
    chk("neg_queue_empty", exp_q.size(), 0);
    $display("xfer negative incr done at +%0d", dc - run_cyc);

    run_xfer(2'b01, 1, 2, 2, 3, 5, 0, 1, 32'h400, 7, 1);
    wait_done(dc);
    chk("delay_first_valid", first_valid_cyc, run_cyc + 4);
    chk("delay_done_cyc", dc, run_cyc + 6);
    $display("xfer delay=3 first valid at +%0d", first_valid_cyc - run_cyc);

    // ready low for 3 cycles on beat 2
    rdy_mode = 2; stall_lo = -1; stall_hi = -1;
    run_xfer(2'b01, 1, 4, 4, 0, 8, 0, 2, 32'h800, 20, 3);
    stall_lo = run_cyc + 2; stall_hi = run_cyc + 4;
    repeat (3) @(negedge clk);
    chk("stall_xfer_held", xfer_cnt, 1);
    wait_done(dc);
    chk("stall_done_cyc", dc, run_cyc + 8);
    chk("stall_xfer_cnt", xfer_cnt, 4);
    rdy_mode = 0;
    $display("xfer stall done at +%0d beats=%0d", dc - run_cyc, xfer_cnt);

    // INT2EXT with int_cnt_en pattern 1,0,1,1
    en_mode = 1; en_pat = 4'b1101;
    run_xfer(2'b10, 1, 4, 4, 0, 3, 0, 1, 32'h2000, 256, 2);
    wait_done(dc);
    chk("i2e_en_cnt", en_cnt, 3);
    chk("i2e_xfer_cnt", xfer_cnt, 4);
    en_mode = 0;
    $display("xfer i2e done at +%0d beats=%0d", dc - run_cyc, xfer_cnt);

    // abort on an accepted beat
    run_xfer(2'b01, 1, 8, 8, 0, 0, 0, 1, 32'h0, 0, 1);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    wait_done(dc);
    chk("abort_done_cyc", dc, run_cyc + 3);
    chk("abort_xfer_cnt", xfer_cnt, 2);
    chk("abort_left", exp_q.size(), 6);
    exp_q.delete();
    $display("xfer abort done at +%0d beats=%0d", dc - run_cyc, xfer_cnt);

    // abort during a stall: beat still completes
    rdy_mode = 2; stall_lo = -1; stall_hi = -1;
    run_xfer(2'b01, 1, 8, 8, 0, 0, 0, 1, 32'h0, 0, 1);
    stall_lo = run_cyc + 3; stall_hi = run_cyc + 5;
    @(posedge clk); #1;
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    wait_done(dc);
    chk("abort_stall_done_cyc", dc, run_cyc + 7);
    chk("abort_stall_xfer_cnt", xfer_cnt, 3);
    chk("abort_stall_left", exp_q.size(), 5);
    exp_q.delete();
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    $display("xfer abort-in-stall done at +%0d beats=%0d", dc - run_cyc, xfer_cnt);

    // reset mid-transfer
    run_xfer(2'b01, 1, 8, 8, 0, 0, 0, 1, 32'h0, 85, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("mrst_done", done, 1);
    chk("mrst_dbvalid", databus_valid, 0);
    chk("mrst_wstrb", databus_wstrb, 0);
    chk("mrst_valid_we", {valid, we}, 0);
    chk("mrst_xfer_cnt", xfer_cnt, 0);
    chk("mrst_addr", addr, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    $display("xfer reset mid-transfer handled");

    // randomized transfers
    for (int t = 0; t < 24; t++) begin
      int it, du, pe, de, gap, exp_dc;
      it = $urandom_range(1, 3); du = $urandom_range(1, 4);
      pe = $urandom_range(1, 6); de = $urandom_range(0, 3);
      rdy_mode = t % 2;
      run_xfer(2'($urandom_range(1, 2)), it, du, pe, de, $urandom_range(0, 1023),
               $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom,
               $urandom_range(0, 1023), $urandom_range(0, 1023));
      wait_done(dc);
      chk("rnd_xfer_cnt", xfer_cnt, it * du);
      chk("rnd_queue_empty", exp_q.size(), 0);
      if (rdy_mode == 0) begin
        gap = (pe > du) ? pe - du : 0;
        exp_dc = run_cyc + 1 + de + it * du + (it - 1) * gap;
        chk("rnd_first_valid", first_valid_cyc, run_cyc + 1 + de);
        chk("rnd_done_cyc", dc, exp_dc);
      end
      $display("rnd xfer %0d dir=%b iter=%0d duty=%0d period=%0d delay=%0d beats=%0d cycles=%0d",
               t, exp_dir, it, du, pe, de, xfer_cnt, dc - run_cyc);
      exp_q.delete();
    end
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
